// File: rtl/ysyx_23060240_csr_pkg.sv
// ysyx_23060240_csr_pkg: CSR addresses, csr_op encodings, mstatus fields and cause codes.
// Counter addresses are only decoded when CSR_COUNTERS_EN is defined.
package ysyx_23060240_csr_pkg;
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam int CAUSE_ECALL_M = 11;
endpackage

// File: rtl/ysyx_23060240_csr_file_if.sv
// ysyx_23060240_csr_file_if: commit-time CSR access, trap and redirect signals.
// master is the retire stage, slave is the CSR file.
interface ysyx_23060240_csr_file_if #(parameter int XLEN = 32);
  logic            commit;
  logic [XLEN-1:0] pc;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_src_zero;
  logic            ecall;
  logic            mret;
  logic [XLEN-1:0] csr_rdata;
  logic            illegal;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output commit, pc, csr_op, csr_addr, csr_wdata, csr_src_zero, ecall, mret,
    input  csr_rdata, illegal, redirect, redirect_pc
  );
  modport slave (
    input  commit, pc, csr_op, csr_addr, csr_wdata, csr_src_zero, ecall, mret,
    output csr_rdata, illegal, redirect, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060240_csr_counter.sv
// ysyx_23060240_csr_counter: 2*W-bit counter with increment enable and per-half write ports.
// A write to either half wins over the increment for that cycle.
module ysyx_23060240_csr_counter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc_i,
  input  logic           wr_lo_i,
  input  logic           wr_hi_i,
  input  logic [W-1:0]   wdata_i,
  output logic [2*W-1:0] cnt_o
);
  logic [2*W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = wr_lo_i ? {cnt_q[2*W-1:W], wdata_i} :
                      wr_hi_i ? {wdata_i, cnt_q[W-1:0]} :
                      inc_i   ? cnt_q + (2*W)'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ysyx_23060240_csr_file.sv
// ysyx_23060240_csr_file: machine-mode CSR file with CSRRW/RS/RC, ecall/mret and illegal flagging.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module ysyx_23060240_csr_file
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] MHARTID     = '0,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M)
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060240_csr_file_if.slave bus
);
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mstatus, old, nval;
  logic            op_en, src_wr, imp, ro, ill, trap, ret, we;
`ifdef CSR_COUNTERS_EN
  logic [2*XLEN-1:0] mcycle, minstret;
  ysyx_23060240_csr_counter #(.W(XLEN)) u_mcycle (
    .clk, .rst_n,
    .inc_i   (1'b1),
    .wr_lo_i (we && bus.csr_addr == CSR_MCYCLE),
    .wr_hi_i (we && bus.csr_addr == CSR_MCYCLEH),
    .wdata_i (nval),
    .cnt_o   (mcycle)
  );
  ysyx_23060240_csr_counter #(.W(XLEN)) u_minstret (
    .clk, .rst_n,
    .inc_i   (bus.commit),
    .wr_lo_i (we && bus.csr_addr == CSR_MINSTRET),
    .wr_hi_i (we && bus.csr_addr == CSR_MINSTRETH),
    .wdata_i (nval),
    .cnt_o   (minstret)
  );
`endif
  // Only MIE/MPIE are stored; MPP is hardwired to M-mode.
  always_comb begin
    mstatus = XLEN'(MSTATUS_RESET);
    mstatus[MSTATUS_MIE] = mie_q;
    mstatus[MSTATUS_MPIE] = mpie_q;
  end
  always_comb begin
    old = '0;
    imp = 1'b1;
    ro = 1'b0;
    case (bus.csr_addr)
      CSR_MSTATUS:  old = mstatus;
      CSR_MTVEC:    old = mtvec_q;
      CSR_MSCRATCH: old = mscratch_q;
      CSR_MEPC:     old = mepc_q;
      CSR_MCAUSE:   old = mcause_q;
      CSR_MVENDORID, CSR_MARCHID: ro = 1'b1;
      CSR_MHARTID: begin
        old = MHARTID;
        ro = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    old = mcycle[XLEN-1:0];
      CSR_MCYCLEH:   old = mcycle[2*XLEN-1:XLEN];
      CSR_MINSTRET:  old = minstret[XLEN-1:0];
      CSR_MINSTRETH: old = minstret[2*XLEN-1:XLEN];
`endif
      default: imp = 1'b0;
    endcase
  end
  assign op_en  = bus.csr_op != CSR_NONE;
  assign src_wr = op_en && !((bus.csr_op == CSR_RS || bus.csr_op == CSR_RC) && bus.csr_src_zero);
  assign ill    = op_en && (!imp || (ro && src_wr));
  assign trap   = bus.commit && bus.ecall;
  assign ret    = bus.commit && bus.mret && !bus.ecall;
  assign we     = bus.commit && src_wr && !ill && !bus.ecall && !bus.mret;
  assign nval   = bus.csr_op == CSR_RW ? bus.csr_wdata :
                  bus.csr_op == CSR_RS ? old | bus.csr_wdata : old & ~bus.csr_wdata;
  assign bus.csr_rdata   = op_en ? old : '0;
  assign bus.illegal     = ill;
  assign bus.redirect    = bus.commit && (bus.ecall || bus.mret);
  assign bus.redirect_pc = bus.ecall ? mtvec_q : mepc_q;
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    if (trap) begin
      mepc_d   = bus.pc & ~XLEN'(3);
      mcause_d = ECALL_CAUSE;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (ret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (we) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mie_d  = nval[MSTATUS_MIE];
          mpie_d = nval[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_d    = nval & ~XLEN'(3);
        CSR_MSCRATCH: mscratch_d = nval;
        CSR_MEPC:     mepc_d     = nval & ~XLEN'(3);
        CSR_MCAUSE:   mcause_d   = nval;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~XLEN'(3);
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
    end
endmodule

// File: tb/tb_ysyx_23060240_csr_file.sv
// tb_ysyx_23060240_csr_file: directed and random CSR traffic against a value-level model,
// with expectations queued by the driver and checked by an independent monitor.
module tb_ysyx_23060240_csr_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ysyx_23060240_csr_file_if #(.XLEN(32)) bus ();
  ysyx_23060240_csr_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string       nm;
    logic [31:0] rd;
    bit          ill;
    bit          re;
    logic [31:0] rpc;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch;
`ifdef CSR_COUNTERS_EN
  logic [63:0] m_cyc, m_ins;
  logic [3:0]  cw = '0;
  logic [31:0] cwd = '0;
  logic        ins_inc = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_cyc <= '0;
      m_ins <= '0;
    end else begin
      m_cyc <= cw[0] ? {m_cyc[63:32], cwd} : cw[1] ? {cwd, m_cyc[31:0]} : m_cyc + 64'd1;
      m_ins <= cw[2] ? {m_ins[63:32], cwd} : cw[3] ? {cwd, m_ins[31:0]} : m_ins + 64'(ins_inc);
    end
`endif
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endfunction
  function automatic void m_reset();
    m_mstatus = 32'h1800;
    m_mtvec = 32'h0;
    m_mepc = 32'h0;
    m_mcause = 32'h0;
    m_mscratch = 32'h0;
  endfunction
  function automatic bit m_read(input logic [11:0] a, output logic [31:0] v, output bit ro);
    v = '0;
    ro = 1'b0;
    case (a)
      12'h300: v = m_mstatus;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hF11, 12'hF12, 12'hF14: ro = 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
`endif
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction
  function automatic void m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: m_mstatus = 32'h1800 | (v & 32'h88);
      12'h305: m_mtvec = v & ~32'h3;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~32'h3;
      12'h342: m_mcause = v;
`ifdef CSR_COUNTERS_EN
      12'hB00: begin cw[0] = 1'b1; cwd = v; end
      12'hB80: begin cw[1] = 1'b1; cwd = v; end
      12'hB02: begin cw[2] = 1'b1; cwd = v; end
      12'hB82: begin cw[3] = 1'b1; cwd = v; end
`endif
      default: ;
    endcase
  endfunction
  task automatic drive(input bit c, input logic [31:0] p, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input bit z, input bit ec, input bit mr);
    bus.commit = c;
    bus.pc = p;
    bus.csr_op = op;
    bus.csr_addr = a;
    bus.csr_wdata = wd;
    bus.csr_src_zero = z;
    bus.ecall = ec;
    bus.mret = mr;
  endtask
  task automatic step(input bit c, input logic [31:0] p, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input bit z, input bit ec, input bit mr, input string nm);
    logic [31:0] old, nv;
    bit ok, ro, wr, ill;
    exp_t e;
    @(posedge clk);
    #1;
    drive(c, p, op, a, wd, z, ec, mr);
    ok = m_read(a, old, ro);
    wr = op != 2'b00 && !(op[1] && z);
    ill = op != 2'b00 && (!ok || (ro && wr));
    e.nm = nm;
    e.rd = op != 2'b00 ? old : 32'h0;
    e.ill = ill;
    e.re = c && (ec || mr);
    e.rpc = ec ? m_mtvec : m_mepc;
    q.push_back(e);
`ifdef CSR_COUNTERS_EN
    cw = '0;
    ins_inc = c;
`endif
    if (c) begin
      if (ec) begin
        m_mepc = p & ~32'h3;
        m_mcause = 32'd11;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (mr) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (wr && !ill) begin
        nv = op == 2'b01 ? wd : op == 2'b10 ? (old | wd) : (old & ~wd);
        m_write(a, nv);
      end
    end
  endtask
  task automatic rd(input logic [11:0] a, input string nm);
    step(1'b0, 32'h0, 2'b10, a, 32'h0, 1'b1, 1'b0, 1'b0, nm);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      me = q.pop_front();
      chk({me.nm, ".rdata"}, 64'(bus.csr_rdata), 64'(me.rd));
      chk({me.nm, ".illegal"}, 64'(bus.illegal), 64'(me.ill));
      chk({me.nm, ".redirect"}, 64'(bus.redirect), 64'(me.re));
      if (me.re) chk({me.nm, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(me.rpc));
    end
  logic [11:0] addrs [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11, 12'hF12,
                              12'hF14, 12'h7C0, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h001};
  initial begin
    drive(1'b0, 32'h0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'h300, "rst_mstatus");
    rd(12'h305, "rst_mtvec");
    rd(12'h341, "rst_mepc");
    step(1'b1, 32'h0, 2'b01, 12'h305, 32'h8000_0103, 1'b0, 1'b0, 1'b0, "rw_mtvec");
    rd(12'h305, "mtvec_masked");
    step(1'b1, 32'h0, 2'b10, 12'h300, 32'h8, 1'b0, 1'b0, 1'b0, "rs_mie");
    rd(12'h300, "mstatus_mie");
    step(1'b1, 32'h0, 2'b10, 12'h300, 32'h80, 1'b1, 1'b0, 1'b0, "rs_zero");
    rd(12'h300, "mstatus_nochg");
    step(1'b1, 32'h8000_0010, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, "ecall");
    rd(12'h341, "ecall_mepc");
    rd(12'h342, "ecall_mcause");
    rd(12'h300, "ecall_mstatus");
    step(1'b1, 32'h0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1, "mret");
    rd(12'h300, "mret_mstatus");
    step(1'b1, 32'h8000_0020, 2'b01, 12'h340, 32'h1234_5678, 1'b0, 1'b1, 1'b0, "ecall_rw");
    rd(12'h340, "mscratch_kept");
    step(1'b1, 32'h0, 2'b01, 12'hF14, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "wr_mhartid");
    step(1'b1, 32'h0, 2'b01, 12'h7C0, 32'h5, 1'b0, 1'b0, 1'b0, "rw_unimpl");
    rd(12'h7C0, "rd_unimpl");
    rd(12'hF14, "rd_mhartid");
    step(1'b1, 32'h0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "wr_mcycle");
    step(1'b0, 32'h0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, "idle");
    rd(12'hB80, "mcycleh_carry");
    rd(12'hB00, "mcycle_low");
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef CSR_COUNTERS_EN
        cw = '0;
        ins_inc = 1'b0;
`endif
        #1 rst_n = 1'b0;
        m_reset();
        #2 rst_n = 1'b1;
        rd(12'h300, "midrst_mstatus");
        rd(12'h342, "midrst_mcause");
      end
      step($urandom_range(3) != 0, $urandom, 2'($urandom_range(3)), addrs[$urandom_range(13)],
           $urandom, $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0, "rand");
    end
    repeat (2) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
